piso_serializer: RTL and testbench

//  Parallel-in, serial-out transmitter. Accepts a WIDTH-bit word through a valid/ready load handshake
//  and emits it one bit per enabled clock on serial_out.
//  LSB-first by default, so a WIDTH-bit right-shift SIPO receiver on the same clk/shift_en holds the

---
 rtl/piso_serializer_pkg.sv | 16 +
 rtl/piso_serializer_bit_counter.sv | 29 ++
 rtl/piso_serializer.sv | 78 +++++++
 tb/tb_piso_serializer.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/piso_serializer_pkg.sv
// Shared definitions for the serial link blocks (serializer and matching receiver).
package piso_serializer_pkg;

  // Default word length shared by transmitter and receiver.
  localparam int unsigned DEF_WIDTH = 4;

  // Legacy-compatible state encodings.
  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

  // Counter width for a mod-w bit counter; at least one bit.
  function automatic int unsigned cnt_width(input int unsigned w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/piso_serializer_bit_counter.sv
// Mod-WIDTH up-counter with enable, synchronous clear and terminal-count flag.
module bit_counter
  import piso_serializer_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned CW    = cnt_width(WIDTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  input  logic          clr,
  output logic [CW-1:0] cnt,
  output logic          tc
);

  assign tc = (cnt == CW'(WIDTH - 1));

  // Count enabled edges; clear has priority, wrap to zero after the terminal count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tc ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in, serial-out transmitter with valid/ready load handshake.
// Bits advance only on shift_en edges; a new word can load on the edge that
// consumes the final bit, giving gap-free back-to-back frames.
module piso_serializer
  import piso_serializer_pkg::*;
#(
  parameter int unsigned WIDTH     = DEF_WIDTH,
  parameter bit          LSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             shift_en,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] parallel_in,
  output logic             serial_out,
  output logic             serial_valid,
  output logic             done
);

  localparam int unsigned CW = cnt_width(WIDTH);

  logic [0:0]       state;
  logic [WIDTH-1:0] shreg;
  logic [CW-1:0]    bit_cnt;
  logic             tc;
  logic             in_shift;
  logic             accept;
  logic             last_bit;

  assign in_shift   = (state == ST_SHIFT);
  assign load_ready = !in_shift || ((bit_cnt == CW'(WIDTH - 1)) && shift_en);
  assign accept     = load_valid && load_ready;
  assign last_bit   = in_shift && shift_en && tc;

  // The transmitted bit is taken straight from a register bit: no input-to-output path.
  assign serial_out = LSB_FIRST ? shreg[0] : shreg[WIDTH-1];

  bit_counter #(
    .WIDTH (WIDTH),
    .CW    (CW)
  ) u_bit_counter (
    .clk   (clk),
    .reset (reset),
    .en    (in_shift && shift_en),
    .clr   (accept || last_bit),
    .cnt   (bit_cnt),
    .tc    (tc)
  );

  // FSM, shift register and frame status flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= ST_IDLE;
      shreg        <= '0;
      serial_valid <= 1'b0;
      done         <= 1'b0;
    end else begin
      done <= last_bit;
      if (accept) begin
        state        <= ST_SHIFT;
        shreg        <= parallel_in;
        serial_valid <= 1'b1;
      end else if (last_bit) begin
        state        <= ST_IDLE;
        shreg        <= '0;
        serial_valid <= 1'b0;
      end else if (in_shift && shift_en) begin
        if (LSB_FIRST) begin
          shreg <= {1'b0, shreg[WIDTH-1:1]};
        end else begin
          shreg <= {shreg[WIDTH-2:0], 1'b0};
        end
      end
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Testbench for piso_serializer: an LSB-first and an MSB-first instance share
// stimulus; a frame-level model predicts every output.
module tb_piso_serializer;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic         shift_en;
  logic         load_valid;
  logic [W-1:0] parallel_in;
  logic [1:0]   rdy, so, sv, dn;

  int tests = 0;
  int fails = 0;

  // Frame-level model: busy flag, word in flight, index of bit on the wire.
  bit           mbusy [2];
  logic [W-1:0] mword [2];
  int           midx  [2];
  bit           mdone [2];

  // Receiver side: right-shift SIPO on instance 0, bit logs for both.
  logic [W-1:0] rx0;
  bit           rxq0[$];
  bit           rxq1[$];
  int           done_cnt;

  always #5 clk = ~clk;

  piso_serializer #(.WIDTH(W), .LSB_FIRST(1'b1)) u_lsb (
    .clk(clk), .reset(reset), .shift_en(shift_en), .load_valid(load_valid),
    .load_ready(rdy[0]), .parallel_in(parallel_in), .serial_out(so[0]),
    .serial_valid(sv[0]), .done(dn[0])
  );

  piso_serializer #(.WIDTH(W), .LSB_FIRST(1'b0)) u_msb (
    .clk(clk), .reset(reset), .shift_en(shift_en), .load_valid(load_valid),
    .load_ready(rdy[1]), .parallel_in(parallel_in), .serial_out(so[1]),
    .serial_valid(sv[1]), .done(dn[1])
  );

  function automatic bit exp_bit(input int k, input logic [W-1:0] w, input int i);
    return (k == 0) ? w[i] : w[W-1-i];
  endfunction

  task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s[%0d] observed=%0h expected=%0h", tag, k, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      mbusy[k] = 0; mword[k] = '0; midx[k] = 0; mdone[k] = 0;
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    for (int k = 0; k < 2; k++) begin
      chk({tag, "_so"}, k, so[k], 0);
      chk({tag, "_sv"}, k, sv[k], 0);
      chk({tag, "_done"}, k, dn[k], 0);
      chk({tag, "_ready"}, k, rdy[k], 1);
    end
  endtask

  // One clock: drive at negedge, check load_ready, capture receiver, clock, check outputs.
  task automatic step(input bit lv, input bit se, input logic [W-1:0] pin);
    bit er [2];
    @(negedge clk);
    load_valid = lv; shift_en = se; parallel_in = pin;
    #1;
    for (int k = 0; k < 2; k++) begin
      er[k] = !mbusy[k] || (midx[k] == W - 1 && se);
      chk("load_ready", k, rdy[k], er[k]);
    end
    if (sv[0] && se) begin rxq0.push_back(so[0]); rx0 = {so[0], rx0[W-1:1]}; end
    if (sv[1] && se) rxq1.push_back(so[1]);
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      mdone[k] = mbusy[k] && se && (midx[k] == W - 1);
      if (lv && er[k]) begin
        mbusy[k] = 1; mword[k] = pin; midx[k] = 0;
      end else if (mbusy[k] && se) begin
        midx[k]++;
        if (midx[k] == W) begin mbusy[k] = 0; midx[k] = 0; end
      end
    end
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("serial_valid", k, sv[k], mbusy[k]);
      chk("serial_out", k, so[k], mbusy[k] ? exp_bit(k, mword[k], midx[k]) : 1'b0);
      chk("done", k, dn[k], mdone[k]);
    end
    if (dn[0]) done_cnt++;
  endtask

  task automatic chk_queue(input string tag, input int k, input bit q[$], input bit e[$]);
    chk({tag, "_len"}, k, q.size(), e.size());
    if (q.size() == e.size())
      for (int i = 0; i < e.size(); i++) chk(tag, k, q[i], e[i]);
  endtask

  task automatic clear_rx();
    rxq0.delete(); rxq1.delete(); rx0 = '0; done_cnt = 0;
  endtask

  initial begin
    bit e[$];
    reset = 1'b0; shift_en = 1'b0; load_valid = 1'b0; parallel_in = '0;
    model_reset(); clear_rx();

    // 1: reset held two cycles, then released.
    repeat (2) @(posedge clk);
    #1 chk_reset_vals("reset_hold");
    @(negedge clk); reset = 1'b1;
    #1 chk_reset_vals("reset_rel");

    // 2: 1011 with shift_en constant.
    clear_rx();
    step(1, 1, 4'b1011);
    repeat (5) step(0, 1, '0);
    e = '{1, 1, 0, 1}; chk_queue("t2_bits", 0, rxq0, e);
    e = '{1, 0, 1, 1}; chk_queue("t2_bits", 1, rxq1, e);
    chk("t2_rxq", 0, rx0, 4'b1011);
    chk("t2_done_cnt", 0, done_cnt, 1);

    // 3: shift_en every other cycle.
    clear_rx();
    step(1, 0, 4'b1011);
    for (int i = 0; i < 5; i++) begin step(0, 0, '0); step(0, 1, '0); end
    e = '{1, 1, 0, 1}; chk_queue("t3_bits", 0, rxq0, e);
    chk("t3_rxq", 0, rx0, 4'b1011);

    // 4: back-to-back words, load_valid held.
    clear_rx();
    step(1, 1, 4'b0110);
    repeat (4) step(1, 1, 4'b1001);
    repeat (5) step(0, 1, '0);
    e = '{0, 1, 1, 0, 1, 0, 0, 1}; chk_queue("t4_bits", 0, rxq0, e);
    chk("t4_done_cnt", 0, done_cnt, 2);

    // 5: pending load while sending 0000.
    clear_rx();
    step(1, 1, 4'b0000);
    repeat (4) step(1, 1, 4'b1111);
    repeat (5) step(0, 1, '0);
    e = '{0, 0, 0, 0, 1, 1, 1, 1}; chk_queue("t5_bits", 0, rxq0, e);

    // 6: reset mid-frame after two bits, then 0011.
    clear_rx();
    step(1, 1, 4'b1010);
    repeat (2) step(0, 1, '0);
    @(negedge clk); reset = 1'b0; load_valid = 1'b0;
    #1 chk_reset_vals("t6_abort");
    model_reset();
    repeat (2) @(posedge clk);
    #1 chk_reset_vals("t6_hold");
    @(negedge clk); reset = 1'b1;
    clear_rx();
    step(1, 1, 4'b0011);
    repeat (5) step(0, 1, '0);
    e = '{0, 0, 1, 1}; chk_queue("t6_bits", 1, rxq1, e);
    e = '{1, 1, 0, 0}; chk_queue("t6_bits", 0, rxq0, e);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++)
      step(bit'($urandom_range(0, 1)), ($urandom % 4) != 0, W'($urandom));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
